ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter DEPTH, default 32, number of RAM words (2**ADDR_W).
REQ-004 clock  in  1  single clock; all state and outputs update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  1  request strobe; sampled only in IDLE.
REQ-007 cmd  in  2  00 read, 01 write, 10 fill, 11 reserved.
REQ-008 req_addr  in  ADDR_W  target address for read/write.
REQ-009 req_data  in  DATA_W  write data, or fill value.
REQ-010 ack  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  high from the cycle after acceptance through the ack cycle.
REQ-012 rd_data  out  DATA_W  last completed read value, held.
REQ-013 rd_valid  out  1  one-cycle pulse coincident with read ack.
REQ-014 ram_address  out  ADDR_W  to the team's single-port RAM address port.
REQ-015 ram_data  out  DATA_W  to the RAM data port.
REQ-016 ram_wren  out  1  to the RAM write-enable port.
REQ-017 ram_q  in  DATA_W  from the RAM read port; 1-cycle registered-address latency.

Function
REQ-018 All outputs SHALL be registered; FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE, FILL, FILL_DONE.
REQ-019 IDLE: when req=1 and cmd is 00/01/10 at edge n, latch cmd/addr/data and leave IDLE; cmd=11 ignored (no ack, no busy).
REQ-020 Requests arriving while busy=1 SHALL be ignored; no queueing.
REQ-021 Write: cycle n+1 in WR: ram_address=addr, ram_data=data, ram_wren=1, ack=1; return to IDLE at n+2.
REQ-022 Read: n+1 RD_ISSUE drives ram_address, ram_wren=0; n+2 RD_WAIT, ram_q captured at end of cycle; n+3 RD_DONE: rd_data updated, rd_valid=1, ack=1; IDLE at n+4.
REQ-023 Fill: write req_data to addresses 0..DEPTH-1, one per cycle, ram_wren=1 for exactly DEPTH consecutive cycles starting n+1.
REQ-024 Fill address counter SHALL stop at DEPTH-1 (no wrap); next cycle FILL_DONE with ack=1, ram_wren=0; then IDLE.
REQ-025 ram_wren SHALL be 0 in every state except WR and FILL.
REQ-026 In IDLE ram_address and ram_data hold their last driven values; rd_data changes only in RD_DONE.
REQ-027 ack and rd_valid SHALL never be high for more than one consecutive cycle.
REQ-028 Back-to-back: req held high in the cycle after ack is accepted as a new request.

Reset
REQ-029 On reset=1 at an edge: state=IDLE, ack=0, busy=0, rd_valid=0, ram_wren=0, ram_address=0, ram_data=0, rd_data=0, fill counter=0.
REQ-030 Reset mid-operation (incl. mid-fill) SHALL abort it: ram_wren=0 from the next cycle, no ack issued; partially filled words remain.
REQ-031 reset has priority over req in the same cycle.

Structure
REQ-032 Package ram_ctrl_pkg SHALL hold the state enum, cmd encodings (CMD_READ, CMD_WRITE, CMD_FILL, CMD_RSVD), and default ADDR_W/DATA_W/DEPTH.
REQ-033 One sub-module, fill_counter: ADDR_W-bit up-counter with clear, enable and terminal-count (==DEPTH-1) flag.

Verification
REQ-034 Write addr 5 data 8'hA5, then read addr 5 -> write ack at n+1 with ram_wren=1; read ack/rd_valid at n+3, rd_data=8'hA5.
REQ-035 Fill with 8'h3C -> ram_wren high exactly 32 cycles, addresses 0..31 in order, ack in cycle 33; reads of 0 and 31 return 8'h3C.
REQ-036 Pulse req (write, addr 2) during an active fill -> ignored; addr 2 holds fill value, only one ack.
REQ-037 Assert reset at fill cycle 10 -> ram_wren=0 next cycle, no ack, all outputs at reset values; addr 9 holds fill value, addr 20 unchanged.
REQ-038 req with cmd=11 -> busy stays 0, no ack, ram_wren stays 0.
REQ-039 Read with req held high through ack -> second read accepted the cycle after ack, two distinct rd_valid pulses.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM controller: default geometry, command
// encodings and the controller state type.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 32;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_FILL  = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_FILL,
    ST_FILL_DONE
  } state_t;

endpackage

// File: rtl/ram_ctrl_fill_counter.sv
// Fill address counter: up-counter with synchronous clear/enable that
// saturates at DEPTH-1 and flags the terminal count.
// Ports: clock, reset (sync, active-high), clear, enable,
//        count (registered), tc_c (combinational count == DEPTH-1).
module fill_counter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              tc_c
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  assign tc_c = (count == LAST);

  // Saturating count: never wraps past the last word.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !tc_c) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Controller for a single-port synchronous RAM (1-cycle read latency).
// Accepts read / write / fill requests while idle and reports completion
// with a one-cycle ack; reads also pulse rd_valid and hold rd_data.
// Ports: clock, reset (sync, active-high)
//        req, cmd, req_addr, req_data       -- request side
//        ack, busy, rd_data, rd_valid        -- status / read result
//        ram_address, ram_data, ram_wren     -- to RAM
//        ram_q                               -- from RAM
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  state_t            state;
  logic [ADDR_W-1:0] fill_count;
  logic              fill_tc_c;
  logic              fill_clear_c;
  logic              fill_en_c;

  // Counter is held cleared while idle so every fill starts at word 0;
  // inside FILL its value equals the address being written this cycle.
  assign fill_clear_c = (state == ST_IDLE);
  assign fill_en_c    = (state == ST_FILL);

  fill_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fill_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (fill_clear_c),
    .enable (fill_en_c),
    .count  (fill_count),
    .tc_c   (fill_tc_c)
  );

  // Controller FSM; every output is computed one edge ahead so it is
  // registered and valid for the whole cycle of the state it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      ack         <= 1'b0;
      busy        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else begin
      ack      <= 1'b0;
      rd_valid <= 1'b0;
      ram_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            case (cmd)
              CMD_WRITE: begin
                state       <= ST_WR;
                ram_address <= req_addr;
                ram_data    <= req_data;
                ram_wren    <= 1'b1;
                ack         <= 1'b1;
                busy        <= 1'b1;
              end
              CMD_READ: begin
                state       <= ST_RD_ISSUE;
                ram_address <= req_addr;
                busy        <= 1'b1;
              end
              CMD_FILL: begin
                state       <= ST_FILL;
                ram_address <= '0;
                ram_data    <= req_data;
                ram_wren    <= 1'b1;
                busy        <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WR: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_RD_ISSUE: begin
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // RAM output for the address issued last cycle is valid now.
          state    <= ST_RD_DONE;
          rd_data  <= ram_q;
          rd_valid <= 1'b1;
          ack      <= 1'b1;
        end
        ST_RD_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_FILL: begin
          if (fill_tc_c) begin
            state <= ST_FILL_DONE;
            ack   <= 1'b1;
          end else begin
            ram_address <= fill_count + ADDR_W'(1);
            ram_wren    <= 1'b1;
          end
        end
        ST_FILL_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever ack is presented.
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          req;
  logic [1:0]    cmd;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          ack;
  logic          busy;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  always #5 clock = ~clock;

  ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .cmd         (cmd),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .ack         (ack),
    .busy        (busy),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  // Single-port RAM device with registered address (read-old-data).
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  // Reference model: intended memory contents.
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    bit            is_read;
    logic [DW-1:0] val;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   negcnt = 0;
  bit   prev_ack = 1'b0;
  bit   prev_rv  = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected completion per ack.
  always @(negedge clock) begin
    negcnt++;
    if (!reset) begin
      if (ack) begin
        chk("ack_single_cycle", !prev_ack, 32'(prev_ack), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1'b0, 32'd1, 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("ack_latency", negcnt == me.due, 32'(negcnt), 32'(me.due));
          chk("busy_at_ack", busy == 1'b1, 32'(busy), 32'd1);
          chk("rd_valid_at_ack", rd_valid == me.is_read, 32'(rd_valid), 32'(me.is_read));
          if (me.is_read) chk("rd_data", rd_data == me.val, 32'(rd_data), 32'(me.val));
        end
      end else if (rd_valid) begin
        chk("rd_valid_without_ack", 1'b0, 32'd1, 32'd0);
      end
      if (rd_valid) chk("rd_valid_single_cycle", !prev_rv, 32'(prev_rv), 32'd0);
    end
    prev_ack = ack;
    prev_rv  = rd_valid;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"},      ack == 1'b0,      32'(ack),         32'd0);
    chk({tag, "_busy"},     busy == 1'b0,     32'(busy),        32'd0);
    chk({tag, "_rd_valid"}, rd_valid == 1'b0, 32'(rd_valid),    32'd0);
    chk({tag, "_ram_wren"}, ram_wren == 1'b0, 32'(ram_wren),    32'd0);
    chk({tag, "_ram_addr"}, ram_address == '0, 32'(ram_address), 32'd0);
    chk({tag, "_ram_data"}, ram_data == '0,   32'(ram_data),    32'd0);
    chk({tag, "_rd_data"},  rd_data == '0,    32'(rd_data),     32'd0);
  endtask

  // Waits (bounded) for the next ack; returns at that negedge.
  task automatic wait_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      seen = ack;
    end
    chk("ack_timeout", seen, 32'(seen), 32'd1);
  endtask

  // Expected completion for a request issued in the current cycle.
  task automatic push_exp(input logic [1:0] c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int extra);
    exp_t e;
    e.is_read = 1'b0;
    e.val     = '0;
    if (c == CMD_READ) begin
      e.is_read = 1'b1;
      e.val     = ref_mem[a];
      e.due     = negcnt + 1 + 3 + extra;
    end else if (c == CMD_WRITE) begin
      ref_mem[a] = d;
      e.due      = negcnt + 1 + 1 + extra;
    end else begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = d;
      e.due = negcnt + 1 + DEPTH + 1 + extra;
    end
    exp_q.push_back(e);
  endtask

  // Called at posedge+1 with the controller idle.
  task automatic do_op(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd = c; req_addr = a; req_data = d; req = 1'b1;
    push_exp(c, a, d, 0);
    @(posedge clock); #1 req = 1'b0;
    wait_ack();
    if (c == CMD_WRITE) begin
      chk("wr_wren", ram_wren == 1'b1, 32'(ram_wren), 32'd1);
      chk("wr_addr", ram_address == a, 32'(ram_address), 32'(a));
      chk("wr_data", ram_data == d, 32'(ram_data), 32'(d));
    end else begin
      chk("rd_wren", ram_wren == 1'b0, 32'(ram_wren), 32'd0);
    end
    @(posedge clock); #1;
  endtask

  task automatic fill_checked(input logic [DW-1:0] v);
    cmd = CMD_FILL; req_addr = AW'($urandom); req_data = v; req = 1'b1;
    push_exp(CMD_FILL, '0, v, 0);
    @(posedge clock); #1 req = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clock);
      if (!(ram_wren && ram_address == AW'(j) && ram_data == v))
        chk("fill_cycle", 1'b0, {15'd0, ram_wren, 8'(ram_address), ram_data},
            {15'd0, 1'b1, 8'(j), v});
      else
        chk("fill_cycle", 1'b1, 32'd0, 32'd0);
    end
    @(negedge clock);
    chk("fill_done_wren", ram_wren == 1'b0, 32'(ram_wren), 32'd0);
    chk("fill_done_ack", ack == 1'b1, 32'(ack), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic rsvd_op();
    cmd = CMD_RSVD; req_addr = AW'($urandom); req_data = DW'($urandom); req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rsvd_busy", busy == 1'b0, 32'(busy), 32'd0);
      chk("rsvd_wren", ram_wren == 1'b0, 32'(ram_wren), 32'd0);
      chk("rsvd_ack", ack == 1'b0, 32'(ack), 32'd0);
    end
    @(posedge clock); #1 req = 1'b0;
  endtask

  task automatic fill_with_intruder(input logic [DW-1:0] v);
    cmd = CMD_FILL; req_data = v; req = 1'b1;
    push_exp(CMD_FILL, '0, v, 0);
    @(posedge clock); #1 req = 1'b0;
    repeat (5) @(posedge clock);
    #1 cmd = CMD_WRITE; req_addr = AW'(2); req_data = ~v; req = 1'b1;
    @(posedge clock); #1 req = 1'b0;
    wait_ack();
    repeat (3) @(negedge clock);
    chk("intruder_busy", busy == 1'b0, 32'(busy), 32'd0);
    @(posedge clock); #1;
    do_op(CMD_READ, AW'(2), '0);
  endtask

  task automatic fill_reset(input logic [DW-1:0] v);
    cmd = CMD_FILL; req_data = v; req = 1'b1;
    for (int i = 0; i < 10; i++) ref_mem[i] = v;
    @(posedge clock); #1 req = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("fill10_addr", ram_address == AW'(9), 32'(ram_address), 32'd9);
    chk("fill10_wren", ram_wren == 1'b1, 32'(ram_wren), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_reset_vals("midfill_rst");
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      chk("post_rst_wren", ram_wren == 1'b0, 32'(ram_wren), 32'd0);
    end
    @(posedge clock); #1;
    do_op(CMD_READ, AW'(9), '0);
    do_op(CMD_READ, AW'(10), '0);
    do_op(CMD_READ, AW'(20), '0);
  endtask

  // req held high through the first ack: second read taken right after.
  task automatic back_to_back(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cmd = CMD_READ; req_addr = a1; req = 1'b1;
    push_exp(CMD_READ, a1, '0, 0);
    push_exp(CMD_READ, a2, '0, 4);
    @(posedge clock); #1 req_addr = a2;
    repeat (4) @(posedge clock);
    #1 req = 1'b0;
    wait_ack();
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; cmd = CMD_READ; req_addr = '0; req_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals("reset");
    @(posedge clock); #1 reset = 1'b0;

    do_op(CMD_WRITE, AW'(5), 8'hA5);
    do_op(CMD_READ,  AW'(5), '0);

    fill_checked(8'h3C);
    do_op(CMD_READ, AW'(0), '0);
    do_op(CMD_READ, AW'(31), '0);

    rsvd_op();
    fill_with_intruder(8'h5A);

    do_op(CMD_WRITE, AW'(20), 8'h77);
    do_op(CMD_WRITE, AW'(10), 8'h66);
    fill_reset(8'hC3);

    do_op(CMD_WRITE, AW'(7), 8'h12);
    do_op(CMD_WRITE, AW'(8), 8'h34);
    back_to_back(AW'(7), AW'(8));

    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 8)       do_op(CMD_WRITE, AW'($urandom), DW'($urandom));
      else if (r < 16) do_op(CMD_READ, AW'($urandom), '0);
      else if (r < 18) rsvd_op();
      else if (r < 19) back_to_back(AW'($urandom), AW'($urandom));
      else             fill_checked(DW'($urandom));
    end

    repeat (4) @(negedge clock);
    chk("scoreboard_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
